// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared fetch-path widths, constants and state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    // Instruction addresses are always word aligned; low bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
// ============================================================================
// Module      : fetch_skid_buffer
// Description : One-entry holding slot for a fetched word that arrived while
//               the IF/ID register was stalled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buffer
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [INST_W-1:0] data_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    output logic [INST_W-1:0] data_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              full_o
);

    logic [INST_W-1:0] data_q;
    logic [ADDR_W-1:0] pc_plus4_q;
    logic              full_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q     <= NOP_INST;
            pc_plus4_q <= '0;
            full_q     <= 1'b0;
        end else if (clear_i) begin
            full_q     <= 1'b0;
        end else if (load_i) begin
            data_q     <= data_i;
            pc_plus4_q <= pc_plus4_i;
            full_q     <= 1'b1;
        end
    end

    assign data_o     = data_q;
    assign pc_plus4_o = pc_plus4_q;
    assign full_o     = full_q;

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module      : inst_fetch_unit
// Description : Instruction fetch FSM with redirect draining and a one-entry
//               skid buffer feeding the IF/ID register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              valid_o
);

    fetch_state_e      state_q,      state_d;
    logic [ADDR_W-1:0] fetch_pc_q,   fetch_pc_d;
    logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;
    logic [INST_W-1:0] inst_q,       inst_d;
    logic [ADDR_W-1:0] pc_plus4_q,   pc_plus4_d;
    logic              valid_q,      valid_d;

    logic              skid_load;
    logic              skid_clear;
    logic [INST_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc_plus4;
    logic              skid_full;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] redirect_pc;
    logic              slot_free;

    assign pc_inc      = fetch_pc_q + 32'd4;
    assign redirect_pc = word_align(redirect_pc_i);
    assign slot_free   = !valid_q || !stall_i;

    fetch_skid_buffer u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (skid_load),
        .clear_i    (skid_clear),
        .data_i     (imem_data_i),
        .pc_plus4_i (pc_inc),
        .data_o     (skid_data),
        .pc_plus4_o (skid_pc_plus4),
        .full_o     (skid_full)
    );

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        inst_d       = inst_q;
        pc_plus4_d   = pc_plus4_q;
        valid_d      = valid_q && stall_i;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        // A redirect kills whatever is presented or buffered, regardless of stall.
        if (redirect_i) begin
            valid_d    = 1'b0;
            skid_clear = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                end
                if (start_i) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect_i) begin
                    if (imem_ack_i) begin
                        fetch_pc_d = redirect_pc;
                        state_d    = start_i ? S_REQ : S_IDLE;
                    end else begin
                        pending_pc_d = redirect_pc;
                        state_d      = S_DRAIN;
                    end
                end else if (imem_ack_i) begin
                    fetch_pc_d = pc_inc;
                    if (slot_free) begin
                        inst_d     = imem_data_i;
                        pc_plus4_d = pc_inc;
                        valid_d    = 1'b1;
                        state_d    = start_i ? S_REQ : S_IDLE;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = S_REQ;
                end else if (!stall_i && skid_full) begin
                    inst_d     = skid_data;
                    pc_plus4_d = skid_pc_plus4;
                    valid_d    = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_DRAIN: begin
                // The stale request must complete before the new address is issued.
                if (imem_ack_i) begin
                    fetch_pc_d = redirect_i ? redirect_pc : pending_pc_q;
                    state_d    = S_REQ;
                end else if (redirect_i) begin
                    pending_pc_d = redirect_pc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
            inst_q       <= NOP_INST;
            pc_plus4_q   <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            inst_q       <= inst_d;
            pc_plus4_q   <= pc_plus4_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req_o  = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign imem_addr_o = fetch_pc_q;
    assign inst_o      = inst_q;
    assign pc_plus4_o  = pc_plus4_q;
    assign valid_o     = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Directed bench for inst_fetch_unit with a wait-state memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] inst_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] wait_n;
    logic [3:0] cnt;
    logic       force_ack;

    always #5 clk_i = ~clk_i;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .inst_o        (inst_o),
        .pc_plus4_o    (pc_plus4_o),
        .valid_o       (valid_o)
    );

    function automatic logic [31:0] w(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory: acks after wait_n request cycles; force_ack injects a stray ack.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          cnt <= '0;
        else if (!imem_req_o || imem_ack_i) cnt <= '0;
        else                                cnt <= cnt + 4'd1;
    end
    assign imem_ack_i  = (imem_req_o && (cnt >= wait_n)) || force_ack;
    assign imem_data_i = w(imem_addr_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = '0; wait_n = 4'd0; force_ack = 1'b0;
        nedge(); nedge();
        check("rst_req",   32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(valid_o),    32'd0);
        check("rst_inst",  inst_o,          32'h0);
        check("rst_pc4",   pc_plus4_o,      32'h0);
        check("rst_addr",  imem_addr_o,     32'h0);
        rst_i = 1'b0; start_i = 1'b1;

        // Zero-wait streaming
        nedge();
        check("s1_addr", imem_addr_o, 32'h0);
        check("s1_req",  32'(imem_req_o), 32'd1);
        check("s1_valid", 32'(valid_o), 32'd0);
        nedge();
        check("s2_addr", imem_addr_o, 32'h4);
        check("s2_inst", inst_o, w(32'h0));
        check("s2_pc4",  pc_plus4_o, 32'h4);
        check("s2_valid", 32'(valid_o), 32'd1);
        nedge();
        check("s3_addr", imem_addr_o, 32'h8);
        check("s3_inst", inst_o, w(32'h4));
        check("s3_pc4",  pc_plus4_o, 32'h8);
        stall_i = 1'b1;

        // Stall while word@8 returns: it must sit in the skid buffer
        nedge();
        check("h1_req",  32'(imem_req_o), 32'd0);
        check("h1_inst", inst_o, w(32'h4));
        check("h1_pc4",  pc_plus4_o, 32'h8);
        check("h1_addr", imem_addr_o, 32'hC);
        nedge();
        check("h2_inst", inst_o, w(32'h4));
        check("h2_valid", 32'(valid_o), 32'd1);
        nedge();
        check("h3_inst", inst_o, w(32'h4));
        stall_i = 1'b0;
        nedge();
        check("h4_inst", inst_o, w(32'h8));
        check("h4_pc4",  pc_plus4_o, 32'hC);
        check("h4_req",  32'(imem_req_o), 32'd1);
        check("h4_addr", imem_addr_o, 32'hC);
        nedge();
        check("h5_inst", inst_o, w(32'hC));
        check("h5_pc4",  pc_plus4_o, 32'h10);
        check("h5_addr", imem_addr_o, 32'h10);

        // Redirect during first cycle of a 2-wait request
        redirect_i = 1'b1; redirect_pc_i = 32'h100; wait_n = 4'd2;
        nedge();
        redirect_i = 1'b0;
        check("d1_addr", imem_addr_o, 32'h10);
        check("d1_req",  32'(imem_req_o), 32'd1);
        check("d1_valid", 32'(valid_o), 32'd0);
        nedge();
        check("d2_addr", imem_addr_o, 32'h10);
        check("d2_valid", 32'(valid_o), 32'd0);
        nedge();
        check("d3_addr", imem_addr_o, 32'h100);
        check("d3_valid", 32'(valid_o), 32'd0);
        wait_n = 4'd0;
        nedge();
        check("d4_inst", inst_o, w(32'h100));
        check("d4_pc4",  pc_plus4_o, 32'h104);
        check("d4_valid", 32'(valid_o), 32'd1);
        check("d4_addr", imem_addr_o, 32'h104);
        stall_i = 1'b1;

        // Redirect while stalled with full skid buffer (unaligned target)
        nedge();
        check("k1_req",  32'(imem_req_o), 32'd0);
        check("k1_inst", inst_o, w(32'h100));
        redirect_i = 1'b1; redirect_pc_i = 32'h203;
        nedge();
        check("k2_valid", 32'(valid_o), 32'd0);
        check("k2_addr",  imem_addr_o, 32'h200);
        redirect_i = 1'b0; stall_i = 1'b0;
        nedge();
        check("k3_inst", inst_o, w(32'h200));
        check("k3_pc4",  pc_plus4_o, 32'h204);
        check("k3_valid", 32'(valid_o), 32'd1);

        // Redirect with same-cycle ack, then async reset mid-request
        redirect_i = 1'b1; redirect_pc_i = 32'h20;
        nedge();
        redirect_i = 1'b0; wait_n = 4'd5;
        check("r1_addr",  imem_addr_o, 32'h20);
        check("r1_valid", 32'(valid_o), 32'd0);
        check("r1_inst",  inst_o, w(32'h200));
        #2 rst_i = 1'b1;
        #1;
        check("r2_req",   32'(imem_req_o), 32'd0);
        check("r2_inst",  inst_o, 32'h0);
        check("r2_pc4",   pc_plus4_o, 32'h0);
        check("r2_addr",  imem_addr_o, 32'h0);
        nedge();
        rst_i = 1'b0; start_i = 1'b0; force_ack = 1'b1; wait_n = 4'd0;
        nedge();
        check("r3_valid", 32'(valid_o), 32'd0);
        check("r3_req",   32'(imem_req_o), 32'd0);
        check("r3_addr",  imem_addr_o, 32'h0);
        force_ack = 1'b0; start_i = 1'b1;
        nedge();
        check("r4_addr", imem_addr_o, 32'h0);
        check("r4_req",  32'(imem_req_o), 32'd1);
        nedge();
        check("r5_inst", inst_o, w(32'h0));
        check("r5_pc4",  pc_plus4_o, 32'h4);

        // Wrap at top of address space
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        nedge();
        redirect_i = 1'b0;
        check("w1_addr",  imem_addr_o, 32'hFFFF_FFFC);
        check("w1_valid", 32'(valid_o), 32'd0);
        nedge();
        check("w2_pc4",  pc_plus4_o, 32'h0);
        check("w2_inst", inst_o, w(32'hFFFF_FFFC));
        check("w2_addr", imem_addr_o, 32'h0);
        start_i = 1'b0;

        // start_i low finishes the in-flight fetch, then idles; output drains
        nedge();
        check("i1_req",   32'(imem_req_o), 32'd0);
        check("i1_valid", 32'(valid_o), 32'd1);
        check("i1_inst",  inst_o, w(32'h0));
        check("i1_addr",  imem_addr_o, 32'h4);
        nedge();
        check("i2_valid", 32'(valid_o), 32'd0);
        check("i2_req",   32'(imem_req_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter SHALL be: RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Port SHALL be: clk_i  input  1  single clock, all state on rising edge.
REQ-003 Port SHALL be: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 Port SHALL be: start_i  input  1  fetch enable.
REQ-005 Port SHALL be: stall_i  input  1  hazard-unit hold of the IF/ID register.
REQ-006 Port SHALL be: redirect_i  input  1  taken branch or jump, flushes fetch.
REQ-007 Port SHALL be: redirect_pc_i  input  32  target address, valid with redirect_i.
REQ-008 Port SHALL be: imem_req_o  output  1  instruction-memory request.
REQ-009 Port SHALL be: imem_addr_o  output  32  request address (word aligned).
REQ-010 Port SHALL be: imem_ack_i  input  1  memory returns data this cycle.
REQ-011 Port SHALL be: imem_data_i  input  32  instruction word, valid with imem_ack_i.
REQ-012 Port SHALL be: inst_o  output  32  instruction to the IF/ID stage.
REQ-013 Port SHALL be: pc_plus4_o  output  32  fetch address + 4 of inst_o.
REQ-014 Port SHALL be: valid_o  output  1  inst_o/pc_plus4_o valid.

Function
REQ-015 FSM states SHALL be IDLE, REQ, HOLD, DRAIN; imem_req_o=1 only in REQ and DRAIN.
REQ-016 IDLE: start_i=1 -> REQ next cycle; else stay.
REQ-017 In REQ, imem_addr_o SHALL equal fetch_pc and remain stable until imem_ack_i (ack may arrive in the first request cycle).
REQ-018 REQ, ack, no redirect, output slot free (valid_o=0 or stall_i=0): next cycle inst_o=imem_data_i, pc_plus4_o=fetch_pc+4, valid_o=1; fetch_pc+=4; stay REQ (back-to-back throughput of one instruction per acked cycle).
REQ-019 REQ, ack, no redirect, valid_o=1 and stall_i=1: data and fetch_pc+4 SHALL be captured in a one-entry skid buffer, fetch_pc+=4, -> HOLD; outputs unchanged.
REQ-020 HOLD: while stall_i=1 outputs and buffer SHALL hold; when stall_i=0 buffer moves to outputs next cycle -> REQ.
REQ-021 stall_i=1 with no ack SHALL hold inst_o, pc_plus4_o, valid_o unchanged.
REQ-022 An output with valid_o=1 SHALL be consumed on any edge where stall_i=0; valid_o drops to 0 if no new word arrives.
REQ-023 redirect_i SHALL have priority over stall_i and ack: valid_o=0 next cycle, skid buffer discarded.
REQ-024 redirect in IDLE or HOLD, or in REQ with ack same cycle: fetch_pc=redirect_pc_i, acked data discarded, -> REQ (IDLE stays IDLE unless start_i=1).
REQ-025 redirect in REQ without ack: redirect_pc_i saved in pending_pc, -> DRAIN; DRAIN keeps old address until ack, discards data, sets fetch_pc=pending_pc, -> REQ.
REQ-026 A second redirect in DRAIN SHALL overwrite pending_pc; redirect with ack in DRAIN SHALL use the new redirect_pc_i.
REQ-027 start_i=0 in REQ SHALL complete the outstanding request normally, then -> IDLE; fetch_pc arithmetic SHALL wrap modulo 2^32; bits [1:0] of redirect_pc_i ignored (forced 0).

Reset
REQ-028 rst_i=1 SHALL immediately force state=IDLE, fetch_pc=RESET_PC, pending_pc=0, skid buffer empty, imem_req_o=0, valid_o=0, inst_o=0, pc_plus4_o=0.
REQ-029 Reset mid-request SHALL abandon the transaction; an ack in the first cycle after release SHALL be ignored while in IDLE.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the fetch-state enum, INST_W=32, ADDR_W=32, NOP_INST=32'h0.
REQ-031 The skid buffer SHALL be a sub-module fetch_skid_buffer (data, pc_plus4, full flag); everything else in inst_fetch_unit.

Verification
REQ-032 Reset, start_i=1, zero-wait memory returning addr-based words -> addresses 0,4,8,12 on consecutive cycles, valid_o high from cycle 3, pc_plus4_o 4,8,12.
REQ-033 Stall 3 cycles while ack arrives for addr 8 -> inst_o holds word@4, HOLD entered, word@8 appears cycle after stall_i drops, no lost or duplicated word.
REQ-034 2-wait memory, redirect_i to 0x100 in first request cycle of 0x10 -> imem_addr_o stays 0x10 until ack, data discarded, next request 0x100, valid_o=0 meanwhile.
REQ-035 redirect_i with stall_i=1 and buffer full -> valid_o=0 next cycle, next fetch at redirect target.
REQ-036 rst_i asserted mid-request at 0x20 -> outputs zero asynchronously, after release first request at RESET_PC.
REQ-037 fetch_pc=0xFFFF_FFFC with ack -> pc_plus4_o=0, next request addr 0.
